// File: rtl/store_buffer.sv
// In-order word store buffer between MEM and data memory, with load forwarding.
// Optional STORE_BUF_COALESCE_EN merges a store into the youngest entry when the word addresses match.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [31:0]                st_pc,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    input  logic                       dm_ready,
    output logic                       dm_we,
    output logic [ADDR_W-1:0]          dm_addr,
    output logic [DATA_W-1:0]          dm_wdata,
    output logic [31:0]                dm_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [ADDR_W-3:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [31:0]       pc_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             full, push, pop, coalesce;
    logic [PTR_W-1:0] fwd_idx;
    logic             unused_lsbs;

    assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    assign full = (count_q == CNT_W'(DEPTH));

`ifdef STORE_BUF_COALESCE_EN
    logic [PTR_W-1:0] young_idx;
    logic             young_match;

    assign young_idx   = tail_q - PTR_ONE;
    assign young_match = (count_q != '0) && (addr_q[young_idx] == st_addr[ADDR_W-1:2]);
    // A lone entry leaving this cycle cannot absorb the store; it becomes a new entry.
    assign coalesce    = st_valid && young_match && !((count_q == CNT_W'(1)) && dm_ready);
    // When full, count cannot be 1, so dm_ready never reaches st_ready.
    assign st_ready    = !full || young_match;
`else
    assign coalesce    = 1'b0;
    assign st_ready    = !full;
`endif

    assign push  = st_valid && st_ready && !coalesce;
    assign dm_we = (count_q != '0);
    assign pop   = dm_we && dm_ready;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q | (st_valid & ~st_ready);
        if (pop)  head_d = head_q + PTR_ONE;
        if (push) tail_d = tail_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry payload carries no reset; validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr[ADDR_W-1:2];
            data_q[tail_q] <= st_data;
            pc_q[tail_q]   <= st_pc;
        end
`ifdef STORE_BUF_COALESCE_EN
        if (coalesce) begin
            data_q[young_idx] <= st_data;
            pc_q[young_idx]   <= st_pc;
        end
`endif
    end

    // Walk oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_q[fwd_idx] == ld_addr[ADDR_W-1:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_q[fwd_idx];
            end
        end
    end

    assign dm_addr  = {addr_q[head_q], 2'b00};
    assign dm_wdata = data_q[head_q];
    assign dm_pc    = pc_q[head_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4); expectations follow STORE_BUF_COALESCE_EN.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr, st_data, st_pc;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        dm_ready;
    logic        dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_pc;
    logic [2:0]  count;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
        .st_ready(st_ready),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .dm_ready(dm_ready), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_pc(dm_pc), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_pc    = p;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic drain();
        dm_ready = 1'b1;
        for (int i = 0; i < 10 && count != 0; i++) tick();
        chk("drain_empty", count, 0);
    endtask

    initial begin
        reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
        ld_addr = 32'hFFFF_FFF0; dm_ready = 1'b1;
        #1;
        chk("rst_st_ready", st_ready, 1);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_ld_hit", ld_hit, 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        tick(); tick();
        reset = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_dm_we", dm_we, 0);
            chk("idle_st_ready", st_ready, 1);
            chk("idle_count", count, 0);
            chk("idle_ld_hit", ld_hit, 0);
        end

        // Single store passes straight through
        push(32'h100, 32'hDEADBEEF, 32'h3000);
        chk("one_dm_we", dm_we, 1);
        chk("one_dm_addr", dm_addr, 32'h100);
        chk("one_dm_wdata", dm_wdata, 32'hDEADBEEF);
        chk("one_dm_pc", dm_pc, 32'h3000);
        chk("one_count", count, 1);
        tick();
        chk("one_count_after", count, 0);
        chk("one_dm_we_after", dm_we, 0);

        // Low address bits are discarded
        push(32'h10B, 32'h55, 32'h3004);
        chk("align_dm_addr", dm_addr, 32'h108);
        tick();

        // Fill, overflow, then ordered drain
        dm_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h400 + 4*i, 32'hA0 + i, 32'h5000 + 4*i);
        chk("full_count", count, 4);
        chk("full_st_ready", st_ready, 0);
        chk("full_overflow_pre", overflow, 0);
        push(32'h480, 32'hEE, 32'h5100);
        chk("full_overflow", overflow, 1);
        chk("full_count_drop", count, 4);
        dm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_dm_we", dm_we, 1);
            chk("drain_dm_addr", dm_addr, 32'h400 + 4*i);
            chk("drain_dm_wdata", dm_wdata, 32'hA0 + i);
            chk("drain_dm_pc", dm_pc, 32'h5000 + 4*i);
            tick();
        end
        chk("drain_count", count, 0);
        chk("drain_dm_we_end", dm_we, 0);
        chk("overflow_sticky", overflow, 1);

        // Simultaneous push and pop keeps count
        dm_ready = 1'b0;
        push(32'h700, 32'h70, 32'h7000);
        dm_ready = 1'b1;
        push(32'h704, 32'h74, 32'h7004);
        chk("pp_count", count, 1);
        chk("pp_dm_addr", dm_addr, 32'h704);
        drain();

        // Forwarding: youngest match wins, same-cycle push is invisible
        dm_ready = 1'b0;
        push(32'h200, 32'h11, 32'h6000);
        push(32'h200, 32'h22, 32'h6004);
        ld_addr = 32'h202; #1;
        chk("fwd_hit", ld_hit, 1);
        chk("fwd_data", ld_data, 32'h22);
        ld_addr = 32'h204; #1;
        chk("fwd_miss_hit", ld_hit, 0);
        chk("fwd_miss_data", ld_data, 0);
        st_valid = 1'b1; st_addr = 32'h204; st_data = 32'h33; st_pc = 32'h6008; #1;
        chk("fwd_same_cycle", ld_hit, 0);
        tick();
        st_valid = 1'b0;
        chk("fwd_next_hit", ld_hit, 1);
        chk("fwd_next_data", ld_data, 32'h33);
        drain();

        // Asynchronous reset mid-cycle discards contents
        dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h600 + 4*i, 32'hC0 + i, 32'h8000);
        chk("pre_rst_count", count, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_dm_we", dm_we, 0);
        chk("async_st_ready", st_ready, 1);
        chk("async_overflow", overflow, 0);
        tick();
        reset = 1'b1;
        dm_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_dm_we", dm_we, 0);
        end

        // Same-address back-to-back stores
        dm_ready = 1'b0;
        push(32'h300, 32'h1, 32'h9000);
        push(32'h300, 32'h2, 32'h9004);
`ifdef STORE_BUF_COALESCE_EN
        chk("coal_count", count, 1);
        chk("coal_head_data", dm_wdata, 32'h2);
        chk("coal_head_pc", dm_pc, 32'h9004);
`else
        chk("coal_count", count, 2);
        chk("coal_head_data", dm_wdata, 32'h1);
        chk("coal_head_pc", dm_pc, 32'h9000);
`endif
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
